// File: rtl/spi_reg_ctrl.sv
// Command/register-bus bridge behind a 32-bit word SPI slave: decodes the command word,
// streams burst writes or prefetched burst reads, and reports sticky error flags.
//
// state | meaning
// IDLE  | no SPI transaction; a leftover bus access may still be finishing
// CMD   | transaction open, waiting for the command word
// WR    | burst write: each received word becomes a bus write
// RD    | burst read: keep rd_buf filled, one fetch outstanding
module spi_reg_ctrl #(
  parameter int          AW      = 16,
  parameter int          TIMEOUT = 255,
  parameter logic [7:0]  SIG     = 8'h5A
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          spi_busy,
  input  logic          spi_read,
  input  logic          spi_valid,
  input  logic [31:0]   spi_rx_data,
  output logic [31:0]   spi_tx_data,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  output logic          err
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [31:0]   POISON   = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_e;

  state_e          state_q, state_d;
  logic            pad_q, pad_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            disc_q, disc_d;
  logic [31:0]     rdbuf_q, rdbuf_d;
  logic            rdvld_q, rdvld_d;
  logic            tout_q, tout_d;
  logic            ovr_q, ovr_d;
  logic            late_q, late_d;
  logic [31:0]     tx_q, tx_d;
  logic            err_q, err_d;
  logic [31:0]     status_w;

  assign status_w    = {SIG, 20'h0, tout_q, ovr_q, late_q, req_q};
  assign spi_tx_data = tx_q;
  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign err         = err_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pad_q   <= 1'b0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      tmr_q   <= '0;
      disc_q  <= 1'b0;
      rdbuf_q <= '0;
      rdvld_q <= 1'b0;
      tout_q  <= 1'b0;
      ovr_q   <= 1'b0;
      late_q  <= 1'b0;
      tx_q    <= {SIG, 24'h0};
      err_q   <= 1'b0;
    end else begin
      pad_q   <= pad_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      tmr_q   <= tmr_d;
      disc_q  <= disc_d;
      rdbuf_q <= rdbuf_d;
      rdvld_q <= rdvld_d;
      tout_q  <= tout_d;
      ovr_q   <= ovr_d;
      late_q  <= late_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    addr_d  = addr_q;
    req_d   = req_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    tmr_d   = tmr_q;
    disc_d  = disc_q;
    rdbuf_d = rdbuf_q;
    rdvld_d = rdvld_q;
    tout_d  = tout_q;
    ovr_d   = ovr_q;
    late_d  = late_q;
    tx_d    = tx_q;

    // An access orphaned by the end of its transaction (disc_q) completes without side effects.
    if (req_q) begin
      if (bus_ack || tmr_q == '0) begin
        req_d  = 1'b0;
        disc_d = 1'b0;
        if (!disc_q) begin
          if (bus_ack) begin
            addr_d = addr_q + AW'(1);
            if (!we_q) begin
              rdbuf_d = bus_rdata;
              rdvld_d = 1'b1;
            end
          end else begin
            tout_d = 1'b1;
            if (!we_q) begin
              rdbuf_d = POISON;
              rdvld_d = 1'b1;
              addr_d  = addr_q + AW'(1);
            end
          end
        end
      end else begin
        tmr_d = tmr_q - TW'(1);
      end
    end

    if (state_q != IDLE && !spi_busy) begin
      state_d = IDLE;
      if (req_d) disc_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (spi_busy) begin
          state_d = CMD;
          pad_d   = 1'b0;
          rdvld_d = 1'b0;
          tout_d  = 1'b0;
          ovr_d   = 1'b0;
          late_d  = 1'b0;
        end
        CMD: if (spi_valid) begin
          addr_d  = spi_rx_data[AW-1:0];
          state_d = spi_rx_data[31] ? WR : RD;
        end
        WR: if (spi_valid) begin
          if (req_q) begin
            ovr_d = 1'b1;
          end else begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            wdata_d = spi_rx_data;
            tmr_d   = TMR_LOAD;
          end
        end
        RD: if (!req_q && !rdvld_q) begin
          req_d = 1'b1;
          we_d  = 1'b0;
          tmr_d = TMR_LOAD;
        end
        default: state_d = IDLE;
      endcase
    end

    // Tx decision uses rd_buf as it stood before any ack landing this same cycle.
    if (spi_read) begin
      if (state_q == RD && spi_busy && pad_q) begin
        if (rdvld_q) begin
          tx_d    = rdbuf_q;
          rdvld_d = 1'b0;
        end else begin
          tx_d   = POISON;
          late_d = 1'b1;
        end
      end else begin
        tx_d = status_w;
      end
      if (state_q != IDLE) pad_d = 1'b1;
    end

    err_d = tout_d | ovr_d | late_d;
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: table of SPI transactions with tx-word and bus-access scoreboards,
// plus hand sequences for busy-drop with a fetch pending and reset mid-access.
module tb_spi_reg_ctrl;
  localparam int AW = 16;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b1;
  logic          spi_busy = 1'b0;
  logic          spi_read = 1'b0;
  logic          spi_valid = 1'b0;
  logic [31:0]   spi_rx_data = '0;
  logic [31:0]   spi_tx_data;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_ack = 1'b0;
  logic [31:0]   bus_rdata = '0;
  logic          err;

  spi_reg_ctrl #(.AW(AW), .TIMEOUT(8), .SIG(8'h5A)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .spi_busy(spi_busy), .spi_read(spi_read),
    .spi_valid(spi_valid), .spi_rx_data(spi_rx_data), .spi_tx_data(spi_tx_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .err(err)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0]      cmd;
    int               nw;
    logic [2:0][31:0] wd;
    int               ack;
    int               gap;
    logic [3:0][31:0] tx;
    int               nacc;
    logic [2:0][15:0] aa;
    logic [2:0][31:0] ad;
    logic             err;
    int               len;
  } vec_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_tx[$];
  vec_t        vecs[5];
  vec_t        v;
  int          n_vec = 0;
  int          n_err = 0;
  int          ack_dly = 0;
  int          req_cnt = 0;
  int          last_len = 0;
  logic        req_seen = 1'b0;
  bus_t        b;

  localparam logic [31:0] ST = 32'h5A00_0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // One cycle of SPI strobes; a read's expected word is queued and checked once it lands.
  task automatic spi_pulse(input logic vld, input logic [31:0] rx, input logic rd,
                           input logic [31:0] exp, input string nm);
    logic [31:0] e;
    spi_valid   = vld;
    spi_rx_data = rx;
    spi_read    = rd;
    if (rd) exp_tx.push_back(exp);
    @(negedge clk_i);
    spi_valid = 1'b0;
    spi_read  = 1'b0;
    if (rd) begin
      e = exp_tx.pop_front();
      chk(nm, spi_tx_data, e);
    end
  endtask

  task automatic wait_bus_idle(input string nm);
    int n = 0;
    while (bus_req && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    chk(nm, {31'h0, bus_req}, 32'h0);
  endtask

  // Bus responder: checks each access as it starts, acks after ack_dly cycles (0 = never).
  initial begin
    forever begin
      @(negedge clk_i);
      if (bus_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          req_cnt  = 0;
          if (exp_bus.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL bus_unexpected: got access we=%b addr=%h, required none", bus_we, bus_addr);
          end else begin
            b = exp_bus.pop_front();
            chk("bus_we", {31'h0, bus_we}, {31'h0, b.we});
            chk("bus_addr", {16'h0, bus_addr}, {16'h0, b.addr});
            if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
          end
        end
        req_cnt++;
        if (ack_dly != 0 && req_cnt == ack_dly) begin
          bus_ack   = 1'b1;
          bus_rdata = {16'h0, bus_addr} + 32'h100;
        end else begin
          bus_ack = 1'b0;
        end
      end else begin
        if (req_seen) last_len = req_cnt;
        req_seen = 1'b0;
        bus_ack  = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0].cmd = 32'h8000_0010; vecs[0].nw = 3; vecs[0].ack = 2; vecs[0].gap = 10;
    vecs[0].wd  = {32'h33, 32'h22, 32'h11};
    vecs[0].tx  = {ST, ST, ST, ST};
    vecs[0].nacc = 3; vecs[0].aa = {16'h12, 16'h11, 16'h10}; vecs[0].ad = {32'h33, 32'h22, 32'h11};
    vecs[0].err = 1'b0; vecs[0].len = 0;

    vecs[1].cmd = 32'h0000_0020; vecs[1].nw = 3; vecs[1].ack = 3; vecs[1].gap = 10;
    vecs[1].wd  = {32'h3, 32'h2, 32'h1};
    vecs[1].tx  = {32'h121, 32'h120, ST, ST};
    vecs[1].nacc = 3; vecs[1].aa = {16'h22, 16'h21, 16'h20}; vecs[1].ad = '0;
    vecs[1].err = 1'b0; vecs[1].len = 0;

    vecs[2].cmd = 32'h0000_0040; vecs[2].nw = 2; vecs[2].ack = 0; vecs[2].gap = 12;
    vecs[2].wd  = '0;
    vecs[2].tx  = {32'h0, 32'hDEAD_BEEF, ST, ST};
    vecs[2].nacc = 2; vecs[2].aa = {16'h0, 16'h41, 16'h40}; vecs[2].ad = '0;
    vecs[2].err = 1'b1; vecs[2].len = 8;

    vecs[3].cmd = 32'h8000_0050; vecs[3].nw = 3; vecs[3].ack = 6; vecs[3].gap = 4;
    vecs[3].wd  = {32'hA3, 32'hA2, 32'hA1};
    vecs[3].tx  = {32'h5A00_0001, ST, ST, 32'h5A00_0008};
    vecs[3].nacc = 2; vecs[3].aa = {16'h0, 16'h51, 16'h50}; vecs[3].ad = {32'h0, 32'hA3, 32'hA1};
    vecs[3].err = 1'b1; vecs[3].len = 0;

    vecs[4].cmd = 32'h7ABC_FFFF; vecs[4].nw = 3; vecs[4].ack = 1; vecs[4].gap = 8;
    vecs[4].wd  = '0;
    vecs[4].tx  = {32'h100, 32'h100FF, ST, 32'h5A00_0004};
    vecs[4].nacc = 3; vecs[4].aa = {16'h0001, 16'h0000, 16'hFFFF}; vecs[4].ad = '0;
    vecs[4].err = 1'b0; vecs[4].len = 0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
    chk("rst_bus_addr", {16'h0, bus_addr}, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_tx", spi_tx_data, ST);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      ack_dly = v.ack;
      for (int j = 0; j < v.nacc; j++) exp_bus.push_back('{v.cmd[31], v.aa[j], v.ad[j]});
      spi_pulse(1'b0, 32'h0, 1'b1, v.tx[0], $sformatf("v%0d_slot0", i));
      spi_busy = 1'b1;
      repeat (2) @(negedge clk_i);
      for (int k = 0; k <= v.nw; k++) begin
        spi_pulse(1'b1, (k == 0) ? v.cmd : v.wd[(k > 0) ? k - 1 : 0], k < v.nw,
                  v.tx[(k < v.nw) ? k + 1 : 0], $sformatf("v%0d_slot%0d", i, k + 1));
        repeat (v.gap - 1) @(negedge clk_i);
      end
      wait_bus_idle($sformatf("v%0d_bus_idle", i));
      repeat (2) @(negedge clk_i);
      spi_busy = 1'b0;
      repeat (3) @(negedge clk_i);
      chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, v.err});
      if (v.len != 0) chk($sformatf("v%0d_req_len", i), last_len, v.len);
    end

    // spi_busy drops while a fetch is outstanding: the access still completes.
    ack_dly = 5;
    exp_bus.push_back('{1'b0, 16'h0030, 32'h0});
    spi_pulse(1'b0, 32'h0, 1'b1, ST, "h1_slot0");
    spi_busy = 1'b1;
    repeat (2) @(negedge clk_i);
    spi_pulse(1'b1, 32'h0000_0030, 1'b1, ST, "h1_slot1");
    repeat (2) @(negedge clk_i);
    chk("h1_req_before_fall", {31'h0, bus_req}, 32'h1);
    spi_busy = 1'b0;
    @(negedge clk_i);
    chk("h1_req_after_fall", {31'h0, bus_req}, 32'h1);
    wait_bus_idle("h1_bus_idle");
    repeat (3) @(negedge clk_i);
    chk("h1_err", {31'h0, err}, 32'h0);

    // Reset lands in the middle of a write that is never acked.
    ack_dly = 0;
    exp_bus.push_back('{1'b1, 16'h0060, 32'h77});
    spi_pulse(1'b0, 32'h0, 1'b1, ST, "h2_slot0");
    spi_busy = 1'b1;
    repeat (2) @(negedge clk_i);
    spi_pulse(1'b1, 32'h8000_0060, 1'b0, 32'h0, "h2_cmd");
    spi_pulse(1'b1, 32'h0000_0077, 1'b0, 32'h0, "h2_wd");
    repeat (3) @(negedge clk_i);
    chk("h2_req_active", {31'h0, bus_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("h2_rst_req", {31'h0, bus_req}, 32'h0);
    chk("h2_rst_we", {31'h0, bus_we}, 32'h0);
    chk("h2_rst_addr", {16'h0, bus_addr}, 32'h0);
    chk("h2_rst_wdata", bus_wdata, 32'h0);
    chk("h2_rst_tx", spi_tx_data, ST);
    chk("h2_rst_err", {31'h0, err}, 32'h0);
    @(negedge clk_i);
    spi_busy = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_i);

    chk("bus_queue_empty", exp_bus.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/register-bus controller behind the 32-bit word-oriented SPI slave.
- Decodes the first received word of each SPI transaction as a command, then streams burst writes or prefetched burst reads to a req/ack register bus with address auto-increment.
- Supplies every outgoing SPI word on the slave's read strobe, and reports sticky error flags in a status word.

Parameters:
- AW, 16, register bus address width in words (1..24).
- TIMEOUT, 255, clk_i cycles to wait for bus_ack before aborting an access (>=1).
- SIG, 8'h5A, signature placed in status word bits [31:24].

Ports:
- clk_i  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_busy  in  1  slave busy; high while ss_n is low (synchronised).
- spi_read  in  1  slave requests the next tx word; spi_tx_data must hold it from the following cycle.
- spi_valid  in  1  one-cycle pulse; spi_rx_data holds a new word.
- spi_rx_data  in  32  received word.
- spi_tx_data  out  32  word to shift out on miso.
- bus_req  out  1  access request, held until bus_ack or timeout.
- bus_we  out  1  1 = write, 0 = read; stable while bus_req is high.
- bus_addr  out  AW  word address.
- bus_wdata  out  32  write data.
- bus_ack  in  1  one-cycle completion; bus_rdata valid in the same cycle.
- bus_rdata  in  32  read data.
- err  out  1  OR of the sticky error flags.

Behaviour:
- Reset values:
  - spi_tx_data = status word.
  - bus_req, bus_we, bus_addr, bus_wdata, err = 0.
  - Error flags clear; FSM in IDLE.
- Status word: {SIG, 20'h0, timeout_err, overrun_err, late_err, bus_pending}.
- Command word: bit31 = 1 write / 0 read; bits[AW-1:0] = start address; other bits are ignored.
- Main FSM:
  - IDLE -> CMD on the spi_busy rising edge. At this edge the slot counter clears and the error flags clear. The slot-0 status word has already been latched, so slot 0 reports the previous transaction's errors.
  - CMD -> WR or RD on the first spi_valid (decoded from bit31). The address register loads bits[AW-1:0].
  - In RD, a fetch of the start address is issued immediately.
  - Any state -> IDLE when spi_busy falls. A pending bus access runs to ack/timeout; its result is discarded.
- Transmit (spi_tx_data updates only at the clock edge ending a spi_read cycle; stable otherwise):
  - Slot 0 and slot 1: status word. Slot 1 is a fixed turnaround pad regardless of fetch progress.
  - Slot >= 2 in RD with rd_buf valid: output rd_buf; clear rd_buf valid; issue fetch of the next address.
  - Slot >= 2 in RD with rd_buf empty: output 32'hDEAD_BEEF and set late_err.
  - CMD/WR/IDLE: status word.
- Read data path:
  - A fetch ack loads rd_buf, sets rd_buf valid, and increments the address.
  - Only one fetch is outstanding at a time.
- Write path:
  - Each spi_valid in WR issues a bus write of spi_rx_data at the current address; the address increments on ack.
  - If spi_valid arrives while a write is still pending: drop the word and set overrun_err.
- Bus handshake:
  - bus_req asserts one cycle after issue and deasserts the cycle after bus_ack.
  - A timeout counter starts at issue. When it reaches TIMEOUT without ack, bus_req drops and timeout_err sets. A read timeout loads rd_buf with 32'hDEAD_BEEF (marked valid); the address still increments.
  - bus_ack with bus_req low is ignored.
- Address increments modulo 2^AW (all-ones wraps to 0).
- Simultaneous events:
  - spi_read and a fetch ack in the same cycle: the tx decision uses rd_buf state before the ack (late_err if empty). The acked data goes to rd_buf.
  - spi_busy fall and spi_valid in the same cycle: the valid is ignored.
- err = timeout_err | overrun_err | late_err, registered.
- Asynchronous reset mid-transfer aborts everything immediately to the reset values.

Test Plan:
- Reset; transaction with cmd 32'h8000_0010 followed by data words 11, 22, 33 -> bus writes 0x0010=11, 0x0011=22, 0x0012=33; spi_tx_data slots 0-3 = 32'h5A00_0000; err = 0.
- Read cmd 32'h0000_0020, bus acks in 3 cycles returning addr+0x100, 4 words clocked -> tx slots: status, status, 0x120, 0x121; bus reads at 0x20, 0x21, 0x22.
- bus_ack never asserted on a read with TIMEOUT = 8 -> bus_req high for exactly 8 cycles then low; slot 2 = 32'hDEAD_BEEF; next transaction's slot 0 = 32'h5A00_0008.
- Write burst with bus_ack delayed by more than one SPI word time -> second word dropped, overrun_err set; next status slot 0 = 32'h5A00_0004.
- Read at address 16'hFFFF -> fetches at 0xFFFF then 0x0000 (wrap).
- spi_busy falls mid-read with a fetch pending, then rst_n pulsed low mid-access -> first case completes the bus cycle then returns IDLE; reset drops bus_req immediately and spi_tx_data = 32'h5A00_0000.
